// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector with a run-time loadable pattern,
// overlapping/non-overlapping modes and an optional saturating match counter.
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   qualifies in
//   in         serial data bit
//   overlap    1 = reuse history after a match, 0 = require PAT_W fresh bits
//   pat        new pattern value (MSB = oldest bit)
//   pat_load   loads pat, restarts the fill and discards any bit on this edge
//   out        registered one-cycle match pulse
//   match_cnt  saturating match count
// Macro SEQ_DETECT_PARAM_CNT_EN builds the match counter; without it match_cnt is tied to 0.
module seq_detect_param #(
    parameter int                PAT_W    = 4,
    parameter logic [PAT_W-1:0]  PAT_INIT = 4'b0110,
    parameter int                CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pat,
    input  logic             pat_load,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);
    logic [PAT_W-1:0] hist, pat_q, nh;
    logic [FW-1:0]    fill, nf;
    logic             m;
    assign nh = {hist[PAT_W-2:0], in};
    assign nf = fill == FULL ? fill : fill + FW'(1);
    assign m  = nf == FULL && nh == pat_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist  <= '0;
            fill  <= '0;
            pat_q <= PAT_INIT;
            out   <= 1'b0;
        end else if (pat_load) begin
            pat_q <= pat;
            fill  <= '0;
            out   <= 1'b0;
        end else if (in_valid) begin
            hist <= nh;
            fill <= m ? (overlap ? FULL : '0) : nf;
            out  <= m;
        end else begin
            out <= 1'b0;
        end
    end
`ifdef SEQ_DETECT_PARAM_CNT_EN
    logic             hit;
    logic [CNT_W-1:0] cnt;
    assign hit = in_valid && !pat_load && m;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (hit && !(&cnt))
            cnt <= cnt + CNT_W'(1);
    end
    assign match_cnt = cnt;
`else
    assign match_cnt = '0;
`endif
endmodule
